// File: rtl/aexm_dmem_resp.sv
// Data-memory responder for the aexm_dcache port: local word RAM behind a
// 1-entry store buffer with load forwarding, plus a req/ack bridge for off-window accesses.
//
// state | meaning
// IDLE  | ready to accept; local accesses complete from here
// EXT   | external access outstanding, ext_req held until ext_ack
// RESP  | external access done, dmem_ack high this cycle
module aexm_dmem_resp #(
  parameter int AW         = 10,
  parameter int LOCAL_BASE = 0
) (
  input  logic        gclk,
  input  logic        grst,
  input  logic        dmem_stb,
  input  logic        dmem_we,
  input  logic [31:0] dmem_adr,
  input  logic [3:0]  dmem_sel,
  input  logic [31:0] aexm_dcache_datao,
  output logic [31:0] aexm_dcache_datai,
  output logic        dmem_ack,
  output logic        ext_req,
  output logic        ext_we,
  output logic [29:0] ext_adr,
  output logic [3:0]  ext_sel,
  output logic [31:0] ext_dato,
  input  logic [31:0] ext_dati,
  input  logic        ext_ack
);

  localparam int TW    = 30 - AW;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {IDLE, EXT, RESP} stateT;
  stateT state, stateNxt;

  logic          accept, isLocal, localLoad, localStore, extStart, extDone;
  logic [AW-1:0] idx;
  logic          unusedAdrLsb;

  logic          sbufValid;
  logic [AW-1:0] sbufIdx;
  logic [3:0]    sbufSel;
  logic [31:0]   sbufData;
  logic          ramWe;

  logic [31:0]   mem [DEPTH];
  logic [31:0]   ramQ;
  logic [3:0]    fwdSel;
  logic [31:0]   fwdData;
  logic [31:0]   extQ;
  logic          rdValid, rdExt;

  assign unusedAdrLsb = ^dmem_adr[1:0];

  // The registered ack blocks re-acceptance of a strobe still held in its ack cycle.
  assign accept     = (state == IDLE) && dmem_stb && !dmem_ack;
  assign isLocal    = (dmem_adr[31:AW+2] == TW'(LOCAL_BASE));
  assign idx        = dmem_adr[AW+1:2];
  assign localLoad  = accept && isLocal && !dmem_we;
  assign localStore = accept && isLocal && dmem_we;
  assign extStart   = accept && !isLocal;
  assign extDone    = (state == EXT) && ext_ack;

  // A local load owns the RAM port; every other cycle the buffer may drain.
  assign ramWe = sbufValid && !localLoad;

  always_ff @(posedge gclk or negedge grst) begin
    if (!grst) state <= IDLE;
    else       state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    case (state)
      IDLE:    if (extStart) stateNxt = EXT;
      EXT:     if (ext_ack)  stateNxt = RESP;
      RESP:    stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge gclk or negedge grst) begin
    if (!grst) begin
      dmem_ack <= 1'b0;
      ext_req  <= 1'b0;
      ext_we   <= 1'b0;
      ext_adr  <= '0;
      ext_sel  <= '0;
      ext_dato <= '0;
    end else begin
      dmem_ack <= localLoad || localStore || extDone;
      if (extStart) begin
        ext_req  <= 1'b1;
        ext_we   <= dmem_we;
        ext_adr  <= dmem_adr[31:2];
        ext_sel  <= dmem_sel;
        ext_dato <= aexm_dcache_datao;
      end else if (extDone) begin
        ext_req  <= 1'b0;
      end
    end
  end

  always_ff @(posedge gclk or negedge grst) begin
    if (!grst) begin
      sbufValid <= 1'b0;
      sbufIdx   <= '0;
      sbufSel   <= '0;
      sbufData  <= '0;
    end else if (localStore) begin
      sbufValid <= 1'b1;
      sbufIdx   <= idx;
      sbufSel   <= dmem_sel;
      sbufData  <= aexm_dcache_datao;
    end else if (ramWe) begin
      sbufValid <= 1'b0;
    end
  end

  always_ff @(posedge gclk) begin
    if (ramWe) begin
      for (int b = 0; b < 4; b++)
        if (sbufSel[b]) mem[sbufIdx][8*b +: 8] <= sbufData[8*b +: 8];
    end
    if (localLoad) ramQ <= mem[idx];
  end

  // Forwarding lanes are frozen at accept so the returned word holds until the next load.
  always_ff @(posedge gclk or negedge grst) begin
    if (!grst) begin
      fwdSel  <= '0;
      fwdData <= '0;
      extQ    <= '0;
      rdValid <= 1'b0;
      rdExt   <= 1'b0;
    end else if (localLoad) begin
      fwdSel  <= (sbufValid && (sbufIdx == idx)) ? sbufSel : 4'h0;
      fwdData <= sbufData;
      rdValid <= 1'b1;
      rdExt   <= 1'b0;
    end else if (extDone && !ext_we) begin
      extQ    <= ext_dati;
      rdValid <= 1'b1;
      rdExt   <= 1'b1;
    end
  end

  always_comb begin
    aexm_dcache_datai = '0;
    if (rdValid) begin
      if (rdExt) begin
        aexm_dcache_datai = extQ;
      end else begin
        for (int b = 0; b < 4; b++)
          aexm_dcache_datai[8*b +: 8] = fwdSel[b] ? fwdData[8*b +: 8] : ramQ[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_aexm_dmem_resp.sv
// Bench for aexm_dmem_resp: directed vector table, hand-timed corner sequences and a
// randomized run against a word/byte-level memory model with a behavioural external slave.
module tb_aexm_dmem_resp;

  localparam int AW = 10;

  logic        gclk = 1'b0;
  logic        grst = 1'b0;
  logic        dmem_stb = 1'b0, dmem_we = 1'b0;
  logic [31:0] dmem_adr = '0;
  logic [3:0]  dmem_sel = '0;
  logic [31:0] dcDato = '0;
  logic [31:0] datai;
  logic        dmem_ack;
  logic        ext_req, ext_we;
  logic [29:0] ext_adr;
  logic [3:0]  ext_sel;
  logic [31:0] ext_dato;
  logic [31:0] ext_dati;
  logic        ext_ack;

  logic        autoEn = 1'b0, autoAck = 1'b0, manAck = 1'b0;
  logic [31:0] autoDati = '0, manDati = '0;
  assign ext_ack  = autoAck | manAck;
  assign ext_dati = manAck ? manDati : autoDati;

  always #5 gclk = ~gclk;

  aexm_dmem_resp #(.AW(AW), .LOCAL_BASE(0)) dut (
    .gclk(gclk), .grst(grst),
    .dmem_stb(dmem_stb), .dmem_we(dmem_we), .dmem_adr(dmem_adr), .dmem_sel(dmem_sel),
    .aexm_dcache_datao(dcDato), .aexm_dcache_datai(datai), .dmem_ack(dmem_ack),
    .ext_req(ext_req), .ext_we(ext_we), .ext_adr(ext_adr), .ext_sel(ext_sel),
    .ext_dato(ext_dato), .ext_dati(ext_dati), .ext_ack(ext_ack)
  );

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] sel);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] byteMask(input logic [3:0] k);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{k[b]}};
    return m;
  endfunction

  // External slave memory: unwritten words read as a fixed address pattern.
  logic [31:0] extMem [logic [29:0]];
  function automatic logic [31:0] extRead(input logic [29:0] w);
    if (extMem.exists(w)) return extMem[w];
    return {w, 2'b00} ^ 32'hA5A5_A5A5;
  endfunction

  initial begin
    int d;
    forever begin
      @(posedge gclk); #1;
      autoAck = 1'b0;
      if (autoEn && ext_req) begin
        d = $urandom_range(0, 3);
        repeat (d) begin @(posedge gclk); #1; end
        if (ext_we) extMem[ext_adr] = merge(extRead(ext_adr), ext_dato, ext_sel);
        else        autoDati = extRead(ext_adr);
        autoAck = 1'b1;
      end
    end
  end

  // Local RAM model: contents plus which bytes are known (RAM is never cleared).
  logic [31:0] locMem   [1 << AW];
  logic [3:0]  locKnown [1 << AW];
  logic [31:0] lastRd   = '0;
  logic [31:0] lastMask = '1;

  task automatic doAccess(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                          input logic [31:0] data, output logic [31:0] rd, output int lat,
                          output logic sawReq, output logic extOk);
    lat = 0; sawReq = 1'b0; extOk = 1'b1;
    dmem_stb = 1'b1; dmem_we = we; dmem_adr = adr; dmem_sel = sel; dcDato = data;
    while (lat < 40) begin
      @(posedge gclk); #1;
      lat++;
      if (ext_req) begin
        sawReq = 1'b1;
        if (ext_adr !== adr[31:2] || ext_we !== we || ext_sel !== sel || (we && ext_dato !== data))
          extOk = 1'b0;
      end
      if (dmem_ack) break;
    end
    rd = datai;
    dmem_stb = 1'b0;
    if (!dmem_ack) begin
      checks++; errors++;
      $display("FAIL ack_timeout: adr %h got no dmem_ack within %0d cycles", adr, lat);
    end
  endtask

  task automatic runOp(input string name, input logic we, input logic [31:0] adr,
                       input logic [3:0] sel, input logic [31:0] data, output logic [31:0] rd);
    logic          isLoc, prevAck, sawReq, extOk;
    logic [AW-1:0] idx;
    logic [31:0]   expRd, expMask;
    int            lat;
    isLoc   = (adr[31:AW+2] == '0);
    idx     = adr[AW+1:2];
    prevAck = dmem_ack;
    if (we) begin
      expRd = lastRd; expMask = lastMask;
    end else if (isLoc) begin
      expRd = locMem[idx]; expMask = byteMask(locKnown[idx]);
    end else begin
      expRd = extRead(adr[31:2]); expMask = '1;
    end
    doAccess(we, adr, sel, data, rd, lat, sawReq, extOk);
    if (isLoc) begin
      check({name, "_lat"}, lat, prevAck ? 2 : 1);
      check({name, "_path"}, {30'd0, sawReq, extOk}, 32'd1);
    end else begin
      check({name, "_path"}, {30'd0, sawReq, extOk}, 32'd3);
    end
    check({name, "_data"}, rd & expMask, expRd & expMask);
    if (!we) begin
      lastRd = expRd; lastMask = expMask;
    end else if (isLoc) begin
      locMem[idx]   = merge(locMem[idx], data, sel);
      locKnown[idx] = locKnown[idx] | sel;
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] data;
    logic [31:0] exp;
  } vecT;

  vecT vec [20];
  logic [3:0] selTab [8];

  initial begin
    logic [31:0] rd;
    int          nAck;
    logic        ok;

    for (int i = 0; i < (1 << AW); i++) begin locMem[i] = '0; locKnown[i] = '0; end
    selTab[0] = 4'hF; selTab[1] = 4'h8; selTab[2] = 4'h4; selTab[3] = 4'h2;
    selTab[4] = 4'h1; selTab[5] = 4'hC; selTab[6] = 4'h3; selTab[7] = 4'h0;

    vec[0]  = '{1'b1, 32'h0000_0010, 4'hF, 32'hAABB_CCDD, 32'h0};
    vec[1]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         32'hAABB_CCDD};
    vec[2]  = '{1'b1, 32'h0000_0010, 4'h4, 32'h1111_1111, 32'h0};
    vec[3]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         32'hAA11_CCDD};
    vec[4]  = '{1'b1, 32'h0000_0000, 4'hF, 32'h0000_0001, 32'h0};
    vec[5]  = '{1'b1, 32'h0000_0004, 4'hF, 32'h0000_0002, 32'h0};
    vec[6]  = '{1'b1, 32'h0000_0008, 4'hF, 32'h0000_0003, 32'h0};
    vec[7]  = '{1'b0, 32'h0000_0000, 4'hF, 32'h0,         32'h0000_0001};
    vec[8]  = '{1'b0, 32'h0000_0004, 4'hF, 32'h0,         32'h0000_0002};
    vec[9]  = '{1'b0, 32'h0000_0008, 4'hF, 32'h0,         32'h0000_0003};
    vec[10] = '{1'b1, 32'h0000_0014, 4'hF, 32'h1234_5678, 32'h0};
    vec[11] = '{1'b1, 32'h0000_0014, 4'h0, 32'hFFFF_FFFF, 32'h0};
    vec[12] = '{1'b0, 32'h0000_0014, 4'h1, 32'h0,         32'h1234_5678};
    vec[13] = '{1'b1, 32'h0000_0018, 4'hF, 32'h0000_0000, 32'h0};
    vec[14] = '{1'b1, 32'h0000_0018, 4'h3, 32'h5555_5555, 32'h0};
    vec[15] = '{1'b0, 32'h0000_0018, 4'h8, 32'h0,         32'h0000_5555};
    // 0x10 + 4*2^AW has a nonzero window tag, so it leaves the local RAM.
    vec[16] = '{1'b0, 32'h0000_1010, 4'hF, 32'h0,         32'hA5A5_B5B5};
    vec[17] = '{1'b1, 32'h8000_0004, 4'hF, 32'hCAFE_F00D, 32'h0};
    vec[18] = '{1'b0, 32'h8000_0004, 4'hF, 32'h0,         32'hCAFE_F00D};
    vec[19] = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         32'hAA11_CCDD};

    repeat (3) @(posedge gclk);
    #1;
    check("rst_datai", datai, 32'h0);
    check("rst_ack", {31'd0, dmem_ack}, 32'd0);
    check("rst_ext", {ext_req, ext_we, ext_sel, ext_adr}, 36'h0);
    check("rst_dato", ext_dato, 32'h0);
    grst = 1'b1;
    @(posedge gclk); #1;

    // External load, ack after three request cycles.
    dmem_stb = 1'b1; dmem_we = 1'b0; dmem_adr = 32'h8000_0000; dmem_sel = 4'hF;
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge gclk); #1;
      if (!(ext_req === 1'b1 && ext_adr === 30'h2000_0000 && ext_we === 1'b0 &&
            ext_sel === 4'hF && dmem_ack === 1'b0)) ok = 1'b0;
    end
    check("t3_req_window", {31'd0, ok}, 32'd1);
    manDati = 32'hDEAD_BEEF; manAck = 1'b1;
    @(posedge gclk); #1;
    manAck = 1'b0;
    check("t3_req_drop", {31'd0, ext_req}, 32'd0);
    check("t3_ack", {31'd0, dmem_ack}, 32'd1);
    check("t3_data", datai, 32'hDEAD_BEEF);
    dmem_stb = 1'b0;
    @(posedge gclk); #1;
    check("t3_ack_single", {31'd0, dmem_ack}, 32'd0);
    lastRd = 32'hDEAD_BEEF; lastMask = '1;

    autoEn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      runOp($sformatf("vec%0d", i), vec[i].we, vec[i].adr, vec[i].sel, vec[i].data, rd);
      if (!vec[i].we) check($sformatf("vec%0d_exp", i), rd, vec[i].exp);
    end

    // Strobe held through the ack cycle must not be taken as a second request.
    @(posedge gclk); #1;
    dmem_stb = 1'b1; dmem_we = 1'b0; dmem_adr = 32'h0000_0004; dmem_sel = 4'hF;
    nAck = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge gclk); #1;
      if (dmem_ack) nAck++;
      if (i == 1) dmem_stb = 1'b0;
    end
    check("t5_ack_count", nAck, 1);
    check("t5_data", datai, 32'h0000_0002);
    lastRd = 32'h0000_0002; lastMask = '1;

    for (int n = 0; n < 300; n++) begin
      logic        we;
      logic [31:0] adr;
      int          r;
      we = 1'($urandom_range(0, 1));
      r  = $urandom_range(0, 9);
      if (r < 7)       adr = 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
      else if (r == 7) adr = 32'h8000_0000 + 32'($urandom_range(0, 3) * 4);
      else             adr = 32'h0000_1000 + 32'($urandom_range(0, 3) * 4);
      if ($urandom_range(0, 3) == 0) begin @(posedge gclk); #1; end
      runOp($sformatf("rnd%0d", n), we, adr, selTab[$urandom_range(0, 7)], $urandom, rd);
    end

    // Reset during an external wait; a late ack must be ignored.
    autoEn = 1'b0;
    @(posedge gclk); #1;
    dmem_stb = 1'b1; dmem_we = 1'b0; dmem_adr = 32'h8000_0008; dmem_sel = 4'hF;
    @(posedge gclk); #1;
    check("t6_req_up", {31'd0, ext_req}, 32'd1);
    @(posedge gclk); #1;
    grst = 1'b0;
    #1;
    check("t6_rst_req", {31'd0, ext_req}, 32'd0);
    check("t6_rst_ack", {31'd0, dmem_ack}, 32'd0);
    check("t6_rst_datai", datai, 32'h0);
    dmem_stb = 1'b0;
    @(posedge gclk); #1;
    grst = 1'b1;
    @(posedge gclk); #1;
    manDati = 32'h1234_4321; manAck = 1'b1;
    @(posedge gclk); #1;
    manAck = 1'b0;
    nAck = dmem_ack ? 1 : 0;
    ok = ext_req;
    @(posedge gclk); #1;
    if (dmem_ack) nAck++;
    check("t6_late_ack", nAck, 0);
    check("t6_late_req", {31'd0, ok}, 32'd0);
    lastRd = '0; lastMask = '1;
    runOp("t6_after", 1'b0, 32'h0000_0008, 4'hF, 32'h0, rd);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
